// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-engine state encoding, default count width
// and parity-sense constants.
package uart_pkg;

    localparam int unsigned KW_DEF = 19;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // Parity bit the transmitter should have sent for this byte.
    function automatic logic exp_parity(input logic [7:0] d, input logic sense);
        return (sense == ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time down-counter shared by the UART receive and transmit engines;
// expire pulses on the cycle the count is zero and the counter reloads a full bit.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned KW = KW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [KW-1:0] k_l,
    input  logic          load_half,
    input  logic          load_full,
    input  logic          enable,
    output logic          expire
);

    localparam logic [KW-1:0] ONE = KW'(1);

    logic [KW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = enable && (cnt_q == '0);
        if (load_half) begin
            cnt_d = (k_l >> 1) - ONE;
        end else if (load_full) begin
            cnt_d = k_l - ONE;
        end else if (enable) begin
            cnt_d = expire ? (k_l - ONE) : (cnt_q - ONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronises and oversamples rx, deserialises one frame
// (7/8 data bits, optional parity) and maintains the rxrdy/perr/ferr/ovf flags.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int unsigned KW = KW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    input  logic [KW-1:0] k,
    input  logic          eight,
    input  logic          pen,
    input  logic          ohel,
    input  logic          clr_rdy,
    output logic [7:0]    rx_data,
    output logic          rxrdy,
    output logic          perr,
    output logic          ferr,
    output logic          ovf
);

    rx_state_e     state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_s;
    logic          armed_q, armed_d;
    logic [KW-1:0] k_l_q, k_l_d;
    logic          eight_l_q, eight_l_d;
    logic          pen_l_q, pen_l_d;
    logic          ohel_l_q, ohel_l_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rxrdy_q, rxrdy_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          ovf_q, ovf_d;

    logic          complete;
    logic          expire;
    logic          load_half;
    logic          load_full;
    logic          tmr_en;
    logic [KW-1:0] tmr_k;
    logic [7:0]    byte_w;
    logic [2:0]    last_idx;

    assign rx_s = sync_q[1];

    // The half-bit load happens in the same cycle k is latched, so feed the live value then.
    assign tmr_k     = (state_q == IDLE) ? k : k_l_q;
    assign load_half = (state_q == IDLE) && armed_q && !rx_s;
    assign load_full = (state_q == START) && expire && !rx_s;
    assign tmr_en    = (state_q != IDLE);
    assign last_idx  = eight_l_q ? 3'd7 : 3'd6;
    assign byte_w    = eight_l_q ? sh_q : {1'b0, sh_q[7:1]};

    uart_bit_timer #(
        .KW (KW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .k_l       (tmr_k),
        .load_half (load_half),
        .load_full (load_full),
        .enable    (tmr_en),
        .expire    (expire)
    );

    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        k_l_d     = k_l_q;
        eight_l_d = eight_l_q;
        pen_l_d   = pen_l_q;
        ohel_l_d  = ohel_l_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        par_d     = par_q;
        complete  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d   = 1'b0;
                    k_l_d     = k;
                    eight_l_d = eight;
                    pen_l_d   = pen;
                    ohel_l_d  = ohel;
                    state_d   = START;
                end
            end
            START: begin
                if (expire) begin
                    if (!rx_s) begin
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    sh_d  = {rx_s, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == last_idx) begin
                        state_d = pen_l_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (expire) begin
                    par_d   = rx_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (expire) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Completion overrides a coincident clear; the clear still suppresses a new overrun.
    always_comb begin
        rx_data_d = rx_data_q;
        rxrdy_d   = rxrdy_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        ovf_d     = ovf_q;
        if (clr_rdy) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end
        if (complete) begin
            rx_data_d = byte_w;
            rxrdy_d   = 1'b1;
            ferr_d    = ~rx_s;
            perr_d    = pen_l_q & (par_q != exp_parity(byte_w, ohel_l_q));
            ovf_d     = clr_rdy ? 1'b0 : (ovf_q | rxrdy_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync_q    <= '1;
            armed_q   <= 1'b0;
            k_l_q     <= '0;
            eight_l_q <= 1'b0;
            pen_l_q   <= 1'b0;
            ohel_l_q  <= 1'b0;
            idx_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            rx_data_q <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], rx};
            armed_q   <= armed_d;
            k_l_q     <= k_l_d;
            eight_l_q <= eight_l_d;
            pen_l_q   <= pen_l_d;
            ohel_l_q  <= ohel_l_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            rx_data_q <= rx_data_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rx_data = rx_data_q;
    assign rxrdy   = rxrdy_q;
    assign perr    = perr_q;
    assign ferr    = ferr_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine: frames are driven bit by bit on rx and the
// latched byte and flags are compared against hand-computed values.
module tb_uart_rx_engine;

    localparam int unsigned KW = 19;

    // Start edge at pin to rxrdy with k=16, 8N1: 2 sync + 1 detect + 8 half-bit + 9*16.
    localparam int LAT16 = 155;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic [KW-1:0] k;
    logic          eight;
    logic          pen;
    logic          ohel;
    logic          clr_rdy;
    logic [7:0]    rx_data;
    logic          rxrdy;
    logic          perr;
    logic          ferr;
    logic          ovf;

    int n_vec = 0;
    int n_err = 0;
    int lat;

    uart_rx_engine #(
        .KW (KW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .k       (k),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rxrdy   (rxrdy),
        .perr    (perr),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int kk, input logic [7:0] d, input int nb,
                              input bit par_en, input logic par_bit, input logic stop_bit);
        rx = 1'b0;
        cycles(kk);
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            cycles(kk);
        end
        if (par_en) begin
            rx = par_bit;
            cycles(kk);
        end
        rx = stop_bit;
        cycles(kk);
        rx = 1'b1;
    endtask

    task automatic clear_flags();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [7:0] d, input logic rdy,
                             input logic pe, input logic fe, input logic ov);
        chk_eq({tag, ".data"}, 32'(rx_data), 32'(d));
        chk_eq({tag, ".rxrdy"}, 32'(rxrdy), 32'(rdy));
        chk_eq({tag, ".perr"}, 32'(perr), 32'(pe));
        chk_eq({tag, ".ferr"}, 32'(ferr), 32'(fe));
        chk_eq({tag, ".ovf"}, 32'(ovf), 32'(ov));
    endtask

    initial begin
        reset   = 1'b0;
        rx      = 1'b1;
        k       = KW'(16);
        eight   = 1'b1;
        pen     = 1'b0;
        ohel    = 1'b0;
        clr_rdy = 1'b0;
        cycles(4);
        chk_flags("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cycles(10);

        // 8N1 0x55 with latency measurement
        lat = 0;
        fork
            send_frame(16, 8'h55, 8, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 1; i <= 400 && lat == 0; i++) begin
                    @(negedge clk);
                    if (rxrdy === 1'b1) lat = i;
                end
            end
        join
        chk_eq("lat55.in_window", 32'(lat >= LAT16 - 2 && lat <= LAT16), 32'd1);
        chk_flags("f55", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_flags();
        chk_eq("clr.rxrdy", 32'(rxrdy), 32'd0);
        chk_eq("clr.data_hold", 32'(rx_data), 32'h55);
        cycles(32);

        // 7-bit, even parity
        eight = 1'b0;
        pen   = 1'b1;
        ohel  = 1'b0;
        send_frame(16, 8'h41, 7, 1'b1, 1'b0, 1'b1);
        cycles(32);
        chk_flags("p41even_ok", 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_flags();
        send_frame(16, 8'h41, 7, 1'b1, 1'b1, 1'b1);
        cycles(32);
        chk_flags("p41even_bad", 8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
        clear_flags();
        ohel = 1'b1;
        send_frame(16, 8'h41, 7, 1'b1, 1'b1, 1'b1);
        cycles(32);
        chk_flags("p41odd_ok", 8'h41, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_flags();
        eight = 1'b1;
        pen   = 1'b0;
        ohel  = 1'b0;

        // overrun, then clear coincident with completion
        send_frame(16, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
        cycles(32);
        send_frame(16, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
        cycles(32);
        chk_flags("ovf", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
        clear_flags();
        chk_eq("ovf.cleared", 32'(ovf), 32'd0);
        send_frame(16, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
        cycles(32);
        fork
            send_frame(16, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
            begin
                cycles(LAT16 - 1);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        cycles(32);
        chk_flags("clr_at_done", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_flags();

        // false start, framing error, break
        rx = 1'b0;
        cycles(5);
        rx = 1'b1;
        cycles(48);
        chk_flags("glitch", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(16, 8'h00, 8, 1'b0, 1'b0, 1'b0);
        cycles(32);
        chk_flags("ferr", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        clear_flags();
        send_frame(16, 8'h7E, 8, 1'b0, 1'b0, 1'b1);
        cycles(32);
        chk_flags("f7E", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_flags();
        rx = 1'b0;
        cycles(200);
        chk_flags("break1", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        clear_flags();
        cycles(280);
        chk_eq("break.no_rearm", 32'(rxrdy), 32'd0);
        rx = 1'b1;
        cycles(48);
        chk_eq("break.idle", 32'(rxrdy), 32'd0);

        // configuration change mid-frame
        fork
            send_frame(16, 8'hC3, 8, 1'b0, 1'b0, 1'b1);
            begin
                cycles(50);
                k = KW'(32);
            end
        join
        cycles(32);
        chk_flags("k16_frame", 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0);
        clear_flags();
        send_frame(32, 8'h96, 8, 1'b0, 1'b0, 1'b1);
        cycles(64);
        chk_flags("k32_frame", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        k = KW'(16);
        cycles(16);

        // reset during bit 4 of 0xF0
        fork
            send_frame(16, 8'hF0, 8, 1'b0, 1'b0, 1'b1);
            begin
                cycles(85);
                reset = 1'b0;
                cycles(3);
                reset = 1'b1;
                chk_flags("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        join
        cycles(64);
        chk_eq("mid_reset.no_flag", 32'(rxrdy), 32'd0);
        send_frame(16, 8'h81, 8, 1'b0, 1'b0, 1'b1);
        cycles(32);
        chk_flags("f81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Receive half of the full UART attached to the TramelBlaze.
- Oversamples the serial line and deserialises one frame into a byte.
- Produces the data byte and the status flags that the downstream data/status input-port mux presents on in_port.
- Flags are cleared by the processor's read strobe.

Parameters:
- KW, 19, width of the baud bit-time count input k.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rx  in  1  asynchronous serial line, idle high.
- k  in  KW  clocks per bit time; legal range 4..2^KW-1.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  parity enable.
- ohel  in  1  parity sense: 0 = even, 1 = odd.
- clr_rdy  in  1  one-cycle pulse from the port decoder on a data read; clears all flags.
- rx_data  out  8  last received byte; bit7 = 0 in 7-bit mode.
- rxrdy  out  1  new byte available.
- perr  out  1  parity error on the latched byte.
- ferr  out  1  framing error: stop bit sampled low.
- ovf  out  1  overrun: a byte completed while rxrdy was already set.

Behaviour:
- **Reset:**
  - Asynchronous, active-low.
  - rx_data = 8'h00; rxrdy, perr, ferr, ovf = 0.
  - State = IDLE. Counters = 0. Synchroniser flops = 1.
- **Synchroniser:** rx passes through 2 flops to give rx_s. All decisions use rx_s, so there are 2 cycles of input latency.
- **Configuration latch:** k, eight, pen and ohel are latched on leaving IDLE. Changes mid-frame are ignored until the next frame.
- **Bit timer:**
  - Down-counter of width KW.
  - Expiry is the cycle when count == 0; on expiry it reloads.
  - Reload value is k_l-1 for full bit times, (k_l>>1)-1 for the start half-bit.
- **States and transitions:**
  - IDLE: when rx_s == 0, load the half-bit count and go to START.
  - START: on expiry, rx_s == 0 → load k_l-1, clear the bit index, go to DATA. rx_s == 1 → false start, return to IDLE with no flag change.
  - DATA:
    - On each expiry, shift rx_s into the shift register LSB-first and increment the bit index.
    - After 8 bits (eight=1) or 7 bits (eight=0), go to PARITY if pen=1, otherwise go to STOP.
  - PARITY: on expiry, capture the parity bit and go to STOP.
  - STOP: on expiry (mid stop bit), complete the frame and go to IDLE in the same cycle. The next falling edge is detectable one cycle later.
- **Frame completion (single cycle):**
  - rx_data takes the shifted byte. In 7-bit mode it is right-aligned with bit7 = 0.
  - rxrdy is set to 1.
  - ferr = (stop bit == 0).
  - Parity:
    - perr = pen & (captured parity != expected).
    - Expected parity is ^data when ohel=0, and ~^data when ohel=1.
    - Computed over 7 or 8 bits per eight.
  - ovf is set to 1 if rxrdy == 1 and clr_rdy == 0 in that cycle. Once set, ovf is sticky until cleared.
  - perr and ferr reflect only the newest frame (overwritten, not OR'd).
- **Flag clearing:**
  - clr_rdy = 1 clears rxrdy, perr, ferr and ovf on the next edge. rx_data holds its value.
- **Simultaneous clr_rdy and frame completion:**
  - Completion wins: rxrdy = 1; perr and ferr take the new frame's values.
  - ovf is cleared and not set.
- **Break (rx held low):**
  - Produces a frame of zeros with ferr = 1.
  - The engine stays in IDLE until rx_s returns high before arming a new start. An IDLE "armed" bit is set by rx_s == 1.
- **Reset mid-frame:** abandons the frame immediately. No flag is set after release. The first start bit is accepted only after rx_s has been seen high.
- **Frame latency:** for 8N1, rxrdy rises (1 + 8 + 0.5)·k + 2 ±1 cycles after the falling edge of the start bit at the rx pin.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding: IDLE, START, DATA, PARITY, STOP (3-bit localparams).
  - KW default.
  - Parity-sense constants (EVEN = 0, ODD = 1).
- One natural sub-module: uart_bit_timer.
  - Inputs: k_l, load_half, load_full, enable.
  - Output: expire pulse.
  - The same sub-module is reused by the transmit engine.
- Remaining RTL (synchroniser, FSM, shifter, parity, flags) stays in uart_rx_engine.

Test Plan:
- k=16, 8N1, send 0x55 → rxrdy=1 and rx_data=8'h55 about 154 cycles after the start edge; perr=ferr=ovf=0. Pulse clr_rdy → rxrdy=0 next cycle; rx_data stays 8'h55.
- k=16, 7-bit, pen=1, ohel=0; send 0x41 with parity bit 0 → rx_data=8'h41, perr=0. Repeat with parity bit 1 → perr=1.
- k=16, 8N1; send 0xA5, then 0x3C without clearing → rx_data=8'h3C, rxrdy=1, ovf=1. Repeat with clr_rdy pulsed in the exact completion cycle of 0x3C → ovf=0, rxrdy=1.
- rx low glitch of 5 cycles (k=16) → returns to IDLE, no flag set. Then send 0x00 with stop bit 0 → rx_data=8'h00, ferr=1. Hold rx low for 3 frames → no further rxrdy until rx returns high.
- Assert reset (0) for 3 cycles during bit 4 of 0xF0 → all outputs 0 after reset. A following clean 0x81 is received correctly.
- Change k from 16 to 32 mid-frame → the current byte is received at k=16; the next frame is received correctly at k=32.
